// File: rtl/note_lane_judge.sv
// Rhythm-game lane judge: per-lane circular FIFOs of falling note Y positions,
// keypress hit/miss judging, expiry, score/combo/miss accounting. Optional macro: NOTE_COMBO_MULT_EN.
module note_lane_judge #(
    parameter int LANES  = 4,
    parameter int DEPTH  = 8,
    parameter int SPEED  = 2,
    parameter int HIT_Y  = 400,
    parameter int WINDOW = 12
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [7:0]           keycode,
    input  logic                 note_valid,
    input  logic [2:0]           note_lane,
    output logic [10*LANES-1:0]  head_y,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [15:0]          miss_cnt,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [10:0]        LATE_Y  = 11'(HIT_Y + WINDOW);
    localparam logic signed [10:0] HIT_S   = 11'(HIT_Y);
    localparam logic signed [10:0] WIN_S   = 11'(WINDOW);
    localparam logic [10:0]        SPEED_W = 11'(SPEED);

    function automatic logic [7:0] key_of(input logic [2:0] lane);
        case (lane)
            3'd0:    key_of = 8'h04;
            3'd1:    key_of = 8'h16;
            3'd2:    key_of = 8'h07;
            3'd3:    key_of = 8'h09;
            3'd4:    key_of = 8'h0A;
            default: key_of = 8'h00;
        endcase
    endfunction

    function automatic logic [9:0] sat_y(input logic [9:0] y);
        logic [10:0] s;
        s = {1'b0, y} + SPEED_W;
        sat_y = s[10] ? 10'h3FF : s[9:0];
    endfunction

    logic             fs1_q, fs2_q, fs3_q;
    logic             tick;
    logic [7:0]       key_q;
    logic             press_q, press_d;
    logic [2:0]       press_lane_q, press_lane_d;
    logic [15:0]      score_q, miss_cnt_q;
    logic [7:0]       combo_q;
    logic             hit_pulse_q, miss_pulse_q, overflow_q;

    logic [LANES-1:0] lane_hit_w, lane_mpress_w, lane_exp_w, lane_drop_w;
    logic [2:0]       miss_tot;
    logic             hit_any, miss_any;
    logic [15:0]      pts;
    logic [16:0]      score_sum, miss_sum;

    assign tick = fs2_q & ~fs3_q;

    // A press is a fresh keycode that maps to an existing lane; held keys never re-trigger.
    always_comb begin
        press_d      = 1'b0;
        press_lane_d = 3'd0;
        for (int l = 0; l < LANES; l++) begin
            if (keycode == key_of(3'(l)) && keycode != key_q) begin
                press_d      = 1'b1;
                press_lane_d = 3'(l);
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [9:0]         mem_q [DEPTH];
        logic [PW-1:0]      rd_q, wr_q;
        logic [CW-1:0]      cnt_q;
        logic [9:0]         head;
        logic signed [10:0] diff;
        logic               empty, judged, in_win, hit, expire, req, pop, push;

        assign head   = mem_q[rd_q];
        assign empty  = (cnt_q == '0);
        assign judged = press_q && (press_lane_q == 3'(g));
        assign diff   = $signed({1'b0, head}) - HIT_S;
        assign in_win = (diff <= WIN_S) && (diff >= -WIN_S);
        assign hit    = judged && !empty && in_win;
        // A lane under judgement never expires in the same cycle.
        assign expire = !judged && !empty && ({1'b0, head} > LATE_Y);
        assign pop    = hit || expire;
        assign req    = note_valid && (note_lane == 3'(g));
        assign push   = req && (cnt_q != CW'(DEPTH));

        assign lane_hit_w[g]    = hit;
        assign lane_mpress_w[g] = judged && !hit;
        assign lane_exp_w[g]    = expire;
        assign lane_drop_w[g]   = req && !push;
        assign head_y[10*g +: 10] = empty ? 10'h3FF : head;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (tick) begin
                    for (int s = 0; s < DEPTH; s++) mem_q[s] <= sat_y(mem_q[s]);
                end
                if (push) begin
                    mem_q[wr_q] <= '0;
                    wr_q        <= wr_q + PW'(1);
                end
                if (pop) rd_q <= rd_q + PW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_comb begin
        miss_tot = 3'd0;
        for (int l = 0; l < LANES; l++) miss_tot = miss_tot + 3'(lane_exp_w[l]);
        miss_tot = miss_tot + 3'(|lane_mpress_w);
    end

    assign hit_any  = |lane_hit_w;
    assign miss_any = (miss_tot != 3'd0);

`ifdef NOTE_COMBO_MULT_EN
    // Multiplier tier is chosen from the combo before this hit is counted.
    always_comb begin
        if (combo_q < 8'd10)      pts = 16'd10;
        else if (combo_q < 8'd30) pts = 16'd20;
        else                      pts = 16'd40;
    end
`else
    assign pts = 16'd10;
`endif

    assign score_sum = {1'b0, score_q} + {1'b0, pts};
    assign miss_sum  = {1'b0, miss_cnt_q} + 17'(miss_tot);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1_q        <= 1'b0;
            fs2_q        <= 1'b0;
            fs3_q        <= 1'b0;
            key_q        <= 8'h00;
            press_q      <= 1'b0;
            press_lane_q <= 3'd0;
            score_q      <= 16'd0;
            combo_q      <= 8'd0;
            miss_cnt_q   <= 16'd0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            fs1_q        <= frame_clk;
            fs2_q        <= fs1_q;
            fs3_q        <= fs2_q;
            key_q        <= keycode;
            press_q      <= press_d;
            press_lane_q <= press_lane_d;
            hit_pulse_q  <= hit_any;
            miss_pulse_q <= miss_any;
            if (|lane_drop_w) overflow_q <= 1'b1;
            if (miss_any) miss_cnt_q <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
            // Any miss wins over a simultaneous hit for the combo.
            if (miss_any)                         combo_q <= 8'd0;
            else if (hit_any && combo_q != 8'hFF) combo_q <= combo_q + 8'd1;
            if (hit_any) score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign miss_cnt   = miss_cnt_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_note_lane_judge.sv
// Directed bench for note_lane_judge: table of single-note judge scenarios plus
// hand-written sequences for overflow/expiry, hold, reset-mid-judge, combo and same-cycle events.
module tb_note_lane_judge;
    localparam int LANES = 4;

    logic                Clk = 1'b0;
    logic                Reset = 1'b1;
    logic                frame_clk = 1'b0;
    logic [7:0]          keycode = 8'h00;
    logic                note_valid = 1'b0;
    logic [2:0]          note_lane = 3'd0;
    logic [10*LANES-1:0] head_y;
    logic [15:0]         score;
    logic [7:0]          combo;
    logic [15:0]         miss_cnt;
    logic                hit_pulse, miss_pulse, overflow;

    note_lane_judge dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .note_valid(note_valid), .note_lane(note_lane), .head_y(head_y),
        .score(score), .combo(combo), .miss_cnt(miss_cnt),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .overflow(overflow)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] lane_key [5] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0A};

    typedef struct {
        int          lane;
        int          ticks;
        logic [7:0]  key;
        logic        exp_hit;
        logic        exp_miss;
        logic [15:0] exp_score;
        logic [7:0]  exp_combo;
        logic [15:0] exp_miss_cnt;
        logic [9:0]  exp_head;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] hy(input int l);
        return head_y[10*l +: 10];
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1; keycode = 8'h00; note_valid = 1'b0; frame_clk = 1'b0;
        cyc(); cyc();
        Reset = 1'b0;
        cyc();
    endtask

    task automatic spawn(input int lane);
        note_valid = 1'b1; note_lane = 3'(lane);
        cyc();
        note_valid = 1'b0;
    endtask

    task automatic tick();
        frame_clk = 1'b1; cyc(); cyc();
        frame_clk = 1'b0; cyc(); cyc();
    endtask

    initial begin
        int hits;
        int exp_score;

        vecs[0] = '{1, 200, 8'h16, 1'b1, 1'b0, 16'd10, 8'd1, 16'd0, 10'h3FF};
        vecs[1] = '{0,  50, 8'h04, 1'b0, 1'b1, 16'd0,  8'd0, 16'd1, 10'd100};
        vecs[2] = '{2, 194, 8'h07, 1'b1, 1'b0, 16'd10, 8'd1, 16'd0, 10'h3FF};
        vecs[3] = '{3, 206, 8'h09, 1'b1, 1'b0, 16'd10, 8'd1, 16'd0, 10'h3FF};
        vecs[4] = '{3, 193, 8'h09, 1'b0, 1'b1, 16'd0,  8'd0, 16'd1, 10'd386};
        vecs[5] = '{0, 200, 8'h16, 1'b0, 1'b1, 16'd0,  8'd0, 16'd1, 10'd400};
        vecs[6] = '{2, 200, 8'h05, 1'b0, 1'b0, 16'd0,  8'd0, 16'd0, 10'd400};
        vecs[7] = '{3, 200, 8'h0A, 1'b0, 1'b0, 16'd0,  8'd0, 16'd0, 10'd400};

        // Reset state
        do_reset();
        for (int l = 0; l < LANES; l++) chk($sformatf("rst_head%0d", l), 32'(hy(l)), 32'h3FF);
        chk("rst_score", 32'(score), 0);
        chk("rst_combo", 32'(combo), 0);
        chk("rst_miss", 32'(miss_cnt), 0);
        chk("rst_pulses", {30'd0, hit_pulse, miss_pulse}, 0);
        chk("rst_ovf", 32'(overflow), 0);

        // Single-note judge table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            spawn(vecs[i].lane);
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            keycode = vecs[i].key;
            cyc(); cyc();
            chk($sformatf("v%0d_hit", i), 32'(hit_pulse), 32'(vecs[i].exp_hit));
            chk($sformatf("v%0d_misspulse", i), 32'(miss_pulse), 32'(vecs[i].exp_miss));
            keycode = 8'h00;
            cyc();
            chk($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].exp_score));
            chk($sformatf("v%0d_combo", i), 32'(combo), 32'(vecs[i].exp_combo));
            chk($sformatf("v%0d_misscnt", i), 32'(miss_cnt), 32'(vecs[i].exp_miss_cnt));
            chk($sformatf("v%0d_head", i), 32'(hy(vecs[i].lane)), 32'(vecs[i].exp_head));
        end

        // Illegal lanes ignored, then overflow on a full lane, then all expire
        do_reset();
        spawn(4); spawn(5);
        for (int l = 0; l < LANES; l++) chk($sformatf("badlane_head%0d", l), 32'(hy(l)), 32'h3FF);
        chk("badlane_ovf", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) spawn(2);
        chk("full_no_ovf", 32'(overflow), 0);
        spawn(2);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_head", 32'(hy(2)), 0);
        for (int t = 0; t < 210; t++) tick();
        chk("expire_miss", 32'(miss_cnt), 8);
        chk("expire_head", 32'(hy(2)), 32'h3FF);
        chk("expire_ovf_sticky", 32'(overflow), 1);

        // Holding a key yields a single hit
        do_reset();
        spawn(2);
        for (int t = 0; t < 200; t++) tick();
        hits = 0;
        keycode = 8'h07;
        for (int c = 0; c < 1000; c++) begin
            cyc();
            if (hit_pulse) hits++;
        end
        keycode = 8'h00;
        chk("hold_hits", hits, 1);
        chk("hold_score", 32'(score), 10);

        // Reset one cycle after a press abandons the judge
        do_reset();
        spawn(1);
        for (int t = 0; t < 200; t++) tick();
        keycode = 8'h16;
        cyc();
        Reset = 1'b1; keycode = 8'h00;
        cyc();
        chk("rstjudge_hit0", 32'(hit_pulse), 0);
        Reset = 1'b0;
        cyc();
        chk("rstjudge_hit1", 32'(hit_pulse), 0);
        chk("rstjudge_miss1", 32'(miss_pulse), 0);
        chk("rstjudge_score", 32'(score), 0);
        for (int l = 0; l < LANES; l++) chk($sformatf("rstjudge_head%0d", l), 32'(hy(l)), 32'h3FF);

        // Push and pop on the same lane in the judge cycle
        do_reset();
        spawn(1);
        for (int t = 0; t < 200; t++) tick();
        keycode = 8'h16;
        cyc();
        note_valid = 1'b1; note_lane = 3'd1;
        cyc();
        note_valid = 1'b0; keycode = 8'h00;
        chk("pushpop_hit", 32'(hit_pulse), 1);
        chk("pushpop_head", 32'(hy(1)), 0);
        cyc();
        keycode = 8'h16;
        cyc(); cyc();
        chk("pushpop_misspress", 32'(miss_pulse), 1);
        chk("pushpop_head_kept", 32'(hy(1)), 0);
        chk("pushpop_combo", 32'(combo), 0);
        keycode = 8'h00;
        cyc();

        // Expiry and miss-press in the same cycle
        do_reset();
        spawn(0);
        for (int t = 0; t < 206; t++) tick();
        chk("edge_head412", 32'(hy(0)), 412);
        chk("edge_no_expire", 32'(miss_cnt), 0);
        frame_clk = 1'b1; cyc(); cyc();
        frame_clk = 1'b0; keycode = 8'h16;
        cyc(); cyc();
        chk("dual_misspulse", 32'(miss_pulse), 1);
        chk("dual_misscnt", 32'(miss_cnt), 2);
        chk("dual_head", 32'(hy(0)), 32'h3FF);
        keycode = 8'h00;
        cyc();
        chk("dual_pulse_once", 32'(miss_pulse), 0);

        // 31 consecutive hits across four lanes
        do_reset();
        for (int i = 0; i < 31; i++) spawn(i % 4);
        for (int t = 0; t < 200; t++) tick();
        hits = 0;
        for (int i = 0; i < 31; i++) begin
            keycode = lane_key[i % 4];
            cyc();
            if (hit_pulse) hits++;
            keycode = 8'h00;
            cyc();
            if (hit_pulse) hits++;
        end
        cyc();
        if (hit_pulse) hits++;
`ifdef NOTE_COMBO_MULT_EN
        exp_score = 540;
`else
        exp_score = 310;
`endif
        chk("combo_hits", hits, 31);
        chk("combo_val", 32'(combo), 31);
        chk("combo_score", 32'(score), 32'(exp_score));
        chk("combo_nomiss", 32'(miss_cnt), 0);
        for (int l = 0; l < LANES; l++) chk($sformatf("combo_head%0d", l), 32'(hy(l)), 32'h3FF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
